// File: rtl/mem_system_pkg.sv
// Shared types and address-field helpers for the set-associative memory system.
// The helpers are width-agnostic so that any parameterisation of the top can use them.
package mem_system_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB,
        FILL,
        INSTALL,
        DONE
    } state_t;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_INDEX_W  = 8;
    localparam int DEF_OFFSET_W = 3;
    localparam int TAG_W        = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int WPL          = 1 << (DEF_OFFSET_W - 1);
    localparam int CNT_W        = (WPL > 1) ? $clog2(WPL) : 1;

    function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int calc_wpl(input int offset_w);
        return 1 << (offset_w - 1);
    endfunction

    function automatic int calc_cnt_w(input int wpl);
        return (wpl > 1) ? $clog2(wpl) : 1;
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w,
                                             input int offset_w);
        return addr >> (index_w + offset_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w,
                                               input int offset_w);
        return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
    endfunction

    // Word position inside the line; bit 0 of the address is the byte within a 2-byte word.
    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int offset_w);
        return (addr >> 1) & ((32'd1 << (offset_w - 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set tag/valid/dirty plus a full data line.
// Combinational read of the addressed set; synchronous word or whole-line writes.
module cache_way_array
    import mem_system_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 5,
    parameter int INDEX_W = 8,
    parameter int WPL     = 4,
    parameter int CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    index,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [WPL*DATA_W-1:0] rd_line,
    input  logic                  word_we,
    input  logic [CNT_W-1:0]      word_sel,
    input  logic [DATA_W-1:0]     word_data,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [WPL*DATA_W-1:0] line_data,
    input  logic                  line_dirty
);
    localparam int SETS = 1 << INDEX_W;

    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [WPL*DATA_W-1:0] data_mem [SETS];
    logic [SETS-1:0]       valid;
    logic [SETS-1:0]       dirty;

    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_line  = data_mem[index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[index] <= 1'b1;
            dirty[index] <= line_dirty;
        end else if (word_we) begin
            dirty[index] <= 1'b1;
        end
    end

    // Contents need no reset, but a write coinciding with reset must not land.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (line_we) begin
                tag_mem[index]  <= line_tag;
                data_mem[index] <= line_data;
            end else if (word_we) begin
                data_mem[index][word_sel*DATA_W +: DATA_W] <= word_data;
            end
        end
    end

endmodule

// File: rtl/mem_system_assoc.sv
// Write-back, write-allocate cache controller, 1- or 2-way with per-set MRU replacement.
// Misses write back a dirty victim line, then fill the line through a pipelined memory port.
//
//   state   | meaning
//   IDLE    | waiting for a request
//   COMPARE | tag lookup; hit, illegal-request or miss decision
//   WB      | bursting the dirty victim line to memory
//   FILL    | issuing line reads and collecting returns
//   INSTALL | writing the filled (and merged) line into the victim way
//   DONE    | completion pulse; may accept the next request
module mem_system_assoc
    import mem_system_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    parameter int WAYS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);
    localparam int TAG_BITS   = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINE_WORDS = calc_wpl(OFFSET_W);
    localparam int CNT_BITS   = calc_cnt_w(LINE_WORDS);
    localparam int SETS       = 1 << INDEX_W;
    localparam int LINE_BITS  = LINE_WORDS * DATA_W;
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LINE_WORDS - 1);

    state_t state, state_n;

    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data;
    logic                req_wr, req_err;
    logic [TAG_BITS-1:0] req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [CNT_BITS-1:0] req_word;

    logic                victim_way, victim_c;
    logic [TAG_BITS-1:0] victim_tag;
    logic [CNT_BITS-1:0] wb_cnt, issue_cnt, ret_cnt;
    logic                issue_done;
    logic [LINE_BITS-1:0] fill_buf, install_line;
    logic [SETS-1:0]     mru;

    logic                done_q, err_q, hit_q;
    logic [DATA_W-1:0]   dout_q;

    logic [TAG_BITS-1:0]  rd_tag   [2];
    logic                 rd_valid [2];
    logic                 rd_dirty [2];
    logic [LINE_BITS-1:0] rd_line  [2];
    logic [1:0]           hit_vec;
    logic                 hit, hit_way;
    logic                 accept, word_we, line_we;
    logic [DATA_W-1:0]    hit_word, fill_word, victim_word;

    assign req_tag   = TAG_BITS'(addr_tag(32'(req_addr), INDEX_W, OFFSET_W));
    assign req_index = INDEX_W'(addr_index(32'(req_addr), INDEX_W, OFFSET_W));
    assign req_word  = CNT_BITS'(addr_word(32'(req_addr), OFFSET_W));

    // Unbuilt way slot (WAYS=1) reads as permanently invalid, so it never hits or is chosen.
    for (genvar w = 0; w < 2; w++) begin : g_way
        if (w < WAYS) begin : g_on
            cache_way_array #(
                .DATA_W (DATA_W),
                .TAG_W  (TAG_BITS),
                .INDEX_W(INDEX_W),
                .WPL    (LINE_WORDS),
                .CNT_W  (CNT_BITS)
            ) u_array (
                .clk       (clk),
                .rst       (rst),
                .index     (req_index),
                .rd_tag    (rd_tag[w]),
                .rd_valid  (rd_valid[w]),
                .rd_dirty  (rd_dirty[w]),
                .rd_line   (rd_line[w]),
                .word_we   (word_we && (hit_way == 1'(w))),
                .word_sel  (req_word),
                .word_data (req_data),
                .line_we   (line_we && (victim_way == 1'(w))),
                .line_tag  (req_tag),
                .line_data (install_line),
                .line_dirty(req_wr)
            );
        end else begin : g_off
            assign rd_tag[w]   = '0;
            assign rd_valid[w] = 1'b0;
            assign rd_dirty[w] = 1'b0;
            assign rd_line[w]  = '0;
        end
        assign hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
    end

    assign hit     = |hit_vec;
    assign hit_way = ~hit_vec[0];

    always_comb begin
        victim_c = 1'b0;
        if (WAYS > 1) begin
            if (!rd_valid[0])      victim_c = 1'b0;
            else if (!rd_valid[1]) victim_c = 1'b1;
            else                   victim_c = ~mru[req_index];
        end
    end

    always_comb begin
        install_line = fill_buf;
        if (req_wr) install_line[req_word*DATA_W +: DATA_W] = req_data;
    end

    assign hit_word    = rd_line[hit_way][req_word*DATA_W +: DATA_W];
    assign fill_word   = fill_buf[req_word*DATA_W +: DATA_W];
    assign victim_word = rd_line[victim_way][wb_cnt*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        word_we   = 1'b0;
        line_we   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE, DONE: begin
                if (Rd || Wr) begin
                    accept  = 1'b1;
                    state_n = COMPARE;
                end else begin
                    state_n = IDLE;
                end
            end
            COMPARE: begin
                if (req_err) begin
                    state_n = DONE;
                end else if (hit) begin
                    word_we = req_wr;
                    state_n = DONE;
                end else if (rd_valid[victim_c] && rd_dirty[victim_c]) begin
                    state_n = WB;
                end else begin
                    state_n = FILL;
                end
            end
            WB: begin
                mem_wr    = 1'b1;
                mem_addr  = {victim_tag, req_index, wb_cnt, 1'b0};
                mem_wdata = victim_word;
                if (!mem_stall && wb_cnt == LAST) state_n = FILL;
            end
            FILL: begin
                mem_rd = !issue_done;
                if (!issue_done) mem_addr = {req_tag, req_index, issue_cnt, 1'b0};
                if (mem_rvalid && ret_cnt == LAST) state_n = INSTALL;
            end
            INSTALL: begin
                line_we = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr   <= '0;
            req_data   <= '0;
            req_wr     <= 1'b0;
            req_err    <= 1'b0;
            victim_way <= 1'b0;
            victim_tag <= '0;
            wb_cnt     <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            issue_done <= 1'b0;
            fill_buf   <= '0;
            mru        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hit_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            done_q <= (state_n == DONE);
            err_q  <= (state == COMPARE) && req_err;
            hit_q  <= (state == COMPARE) && !req_err && hit;
            if (accept) begin
                req_addr <= Addr;
                req_data <= DataIn;
                req_wr   <= Wr;
                req_err  <= (Rd && Wr) || Addr[0];
            end
            case (state)
                COMPARE: begin
                    if (!req_err) begin
                        if (hit) begin
                            mru[req_index] <= hit_way;
                            if (!req_wr) dout_q <= hit_word;
                        end else begin
                            victim_way <= victim_c;
                            victim_tag <= rd_tag[victim_c];
                            wb_cnt     <= '0;
                            issue_cnt  <= '0;
                            ret_cnt    <= '0;
                            issue_done <= 1'b0;
                        end
                    end
                end
                WB: begin
                    if (!mem_stall) wb_cnt <= wb_cnt + 1'b1;
                end
                FILL: begin
                    if (!issue_done && !mem_stall) begin
                        if (issue_cnt == LAST) issue_done <= 1'b1;
                        else                   issue_cnt  <= issue_cnt + 1'b1;
                    end
                    if (mem_rvalid) begin
                        fill_buf[ret_cnt*DATA_W +: DATA_W] <= mem_rdata;
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                end
                INSTALL: begin
                    mru[req_index] <= victim_way;
                    if (!req_wr) dout_q <= fill_word;
                end
                default: ;
            endcase
        end
    end

    assign Done     = done_q;
    assign err      = err_q;
    assign CacheHit = hit_q;
    assign DataOut  = dout_q;
    assign Stall    = (state == COMPARE) || (state == WB) || (state == FILL) || (state == INSTALL);

endmodule

// File: tb/tb_mem_system_assoc.sv
// Directed bench for mem_system_assoc: behavioural pipelined memory with adjustable
// latency and backpressure, and hand-computed expectations checked by immediate assertions.
module tb_mem_system_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = '0;
    logic [15:0] DataIn = '0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic        mem_stall = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_system_assoc dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_stall (mem_stall),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    // Memory model: word array, in-order read pipeline with latency `lat` (>= 1).
    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    logic [15:0] mem_arr [0:32767];
    rd_t         pend[$];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    logic [15:0] wr_data_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          proto_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            mem_rvalid <= 1'b0;
        end else begin
            if (mem_rd && mem_wr) proto_err = proto_err + 1;
            if (mem_wr && !mem_stall) begin
                mem_arr[mem_addr[15:1]] = mem_wdata;
                wr_log.push_back(mem_addr);
                wr_data_log.push_back(mem_wdata);
            end
            if (mem_rd && !mem_stall) begin
                pend.push_back('{mem_addr, cyc + lat - 1});
                rd_log.push_back(mem_addr);
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_arr[pend[0].addr[15:1]];
                void'(pend.pop_front());
            end else begin
                mem_rvalid <= 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge; returns with time in cycle 1 after acceptance.
    task automatic start_req(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] d, output logic st1);
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
        st1 = Stall;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 1;
        while (Done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_done"}, 32'(Done), 32'd1);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        wr_data_log.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        st1;
        int          cy;
        logic [15:0] a0;

        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'(i) ^ 16'hA5A5;
        mem_arr[15'h091A] = 16'hBEEF;

        repeat (3) @(negedge clk);
        chk("rst_done",  32'(Done), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_hit",   32'(CacheHit), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_dout",  32'(DataOut), 0);
        chk("rst_mrd",   32'(mem_rd), 0);
        chk("rst_mwr",   32'(mem_wr), 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        rst = 1'b0;

        // Cold read miss, then hit on the same word.
        clear_logs();
        start_req(1'b1, 1'b0, 16'h1234, 16'h0, st1);
        wait_done("cold", cy);
        chk("cold_hit",  32'(CacheHit), 0);
        chk("cold_err",  32'(err), 0);
        chk("cold_dout", 32'(DataOut), 32'hBEEF);
        chk("cold_nrd",  32'(rd_log.size()), 4);
        chk("cold_rd0",  32'(rd_log[0]), 32'h1230);
        chk("cold_rd1",  32'(rd_log[1]), 32'h1232);
        chk("cold_rd2",  32'(rd_log[2]), 32'h1234);
        chk("cold_rd3",  32'(rd_log[3]), 32'h1236);
        chk("cold_nwr",  32'(wr_log.size()), 0);

        start_req(1'b1, 1'b0, 16'h1234, 16'h0, st1);
        chk("hit_stall_c1", 32'(st1), 1);
        wait_done("rehit", cy);
        chk("rehit_lat",   32'(cy), 2);
        chk("rehit_stall", 32'(Stall), 0);
        chk("rehit_hit",   32'(CacheHit), 1);
        chk("rehit_dout",  32'(DataOut), 32'hBEEF);
        @(negedge clk);
        chk("rehit_pulse", 32'(Done), 0);
        chk("rehit_hitq",  32'(CacheHit), 0);

        start_req(1'b0, 1'b1, 16'h1236, 16'h7777, st1);
        wait_done("whit", cy);
        chk("whit_lat", 32'(cy), 2);
        chk("whit_hit", 32'(CacheHit), 1);
        start_req(1'b1, 1'b0, 16'h1236, 16'h0, st1);
        wait_done("whit_rd", cy);
        chk("whit_rd_dout", 32'(DataOut), 32'h7777);

        // Two tags in one set: the second allocates way 1 without a write-back.
        clear_logs();
        start_req(1'b0, 1'b1, 16'h0008, 16'h1111, st1);
        wait_done("w0", cy);
        chk("w0_hit", 32'(CacheHit), 0);
        start_req(1'b0, 1'b1, 16'h0808, 16'h2222, st1);
        wait_done("w1", cy);
        chk("w1_hit", 32'(CacheHit), 0);
        chk("conf_nwr", 32'(wr_log.size()), 0);
        start_req(1'b1, 1'b0, 16'h0008, 16'h0, st1);
        wait_done("r0", cy);
        chk("r0_hit",  32'(CacheHit), 1);
        chk("r0_dout", 32'(DataOut), 32'h1111);
        start_req(1'b1, 1'b0, 16'h0808, 16'h0, st1);
        wait_done("r1", cy);
        chk("r1_hit",  32'(CacheHit), 1);
        chk("r1_dout", 32'(DataOut), 32'h2222);

        // Way 0 made MRU; the next conflicting miss evicts dirty way 1.
        start_req(1'b1, 1'b0, 16'h0008, 16'h0, st1);
        wait_done("mru0", cy);
        chk("mru0_hit", 32'(CacheHit), 1);
        clear_logs();
        start_req(1'b1, 1'b0, 16'h1008, 16'h0, st1);
        wait_done("ev", cy);
        chk("ev_hit",  32'(CacheHit), 0);
        chk("ev_dout", 32'(DataOut), 32'hADA1);
        chk("ev_nwr",  32'(wr_log.size()), 4);
        chk("ev_wa0",  32'(wr_log[0]), 32'h0808);
        chk("ev_wd0",  32'(wr_data_log[0]), 32'h2222);
        chk("ev_wa3",  32'(wr_log[3]), 32'h080E);
        clear_logs();
        start_req(1'b1, 1'b0, 16'h0808, 16'h0, st1);
        wait_done("back", cy);
        chk("back_hit",  32'(CacheHit), 0);
        chk("back_dout", 32'(DataOut), 32'h2222);
        chk("back_wa0",  32'(wr_log[0]), 32'h0008);
        chk("back_wd0",  32'(wr_data_log[0]), 32'h1111);

        // Backpressure: latency 4, memory stalls for three cycles on the second read.
        lat = 4;
        clear_logs();
        start_req(1'b1, 1'b0, 16'h2A4C, 16'h0, st1);
        @(negedge clk);
        @(negedge clk);
        mem_stall = 1'b1;
        a0 = mem_addr;
        chk("bp_rd_on",  32'(mem_rd), 1);
        chk("bp_addr_s", 32'(a0), 32'h2A4A);
        repeat (2) begin
            @(negedge clk);
            chk("bp_rd_held",   32'(mem_rd), 1);
            chk("bp_addr_held", 32'(mem_addr), 32'h2A4A);
        end
        @(negedge clk);
        mem_stall = 1'b0;
        wait_done("bp", cy);
        chk("bp_hit",  32'(CacheHit), 0);
        chk("bp_dout", 32'(DataOut), 32'hB083);
        chk("bp_nrd",  32'(rd_log.size()), 4);
        chk("bp_rd0",  32'(rd_log[0]), 32'h2A48);
        chk("bp_rd1",  32'(rd_log[1]), 32'h2A4A);
        chk("bp_rd3",  32'(rd_log[3]), 32'h2A4E);
        lat = 1;

        // Illegal requests complete in two cycles with err and touch nothing.
        clear_logs();
        start_req(1'b1, 1'b1, 16'h0808, 16'h5555, st1);
        wait_done("ill_rw", cy);
        chk("ill_rw_lat", 32'(cy), 2);
        chk("ill_rw_err", 32'(err), 1);
        chk("ill_rw_hit", 32'(CacheHit), 0);
        @(negedge clk);
        chk("ill_err_pulse", 32'(err), 0);
        start_req(1'b1, 1'b0, 16'h0003, 16'h0, st1);
        wait_done("ill_odd", cy);
        chk("ill_odd_lat", 32'(cy), 2);
        chk("ill_odd_err", 32'(err), 1);
        chk("ill_mem", 32'(rd_log.size() + wr_log.size()), 0);
        start_req(1'b1, 1'b0, 16'h0808, 16'h0, st1);
        wait_done("ill_chk", cy);
        chk("ill_chk_hit",  32'(CacheHit), 1);
        chk("ill_chk_dout", 32'(DataOut), 32'h2222);

        // Reset in the middle of a fill.
        start_req(1'b1, 1'b0, 16'h3456, 16'h0, st1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_done",  32'(Done), 0);
        chk("mid_stall", 32'(Stall), 0);
        chk("mid_hit",   32'(CacheHit), 0);
        chk("mid_err",   32'(err), 0);
        chk("mid_dout",  32'(DataOut), 0);
        chk("mid_mrd",   32'(mem_rd), 0);
        chk("mid_mwr",   32'(mem_wr), 0);
        chk("mid_maddr", 32'(mem_addr), 0);
        chk("mid_wdata", 32'(mem_wdata), 0);
        rst = 1'b0;
        start_req(1'b1, 1'b0, 16'h3456, 16'h0, st1);
        wait_done("post", cy);
        chk("post_hit",  32'(CacheHit), 0);
        chk("post_dout", 32'(DataOut), 32'hBF8E);

        chk("one_strobe", 32'(proto_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
